// File: rtl/spectral_flux_banded_if.sv
// Bus bundle for spectral_flux_banded: magnitude-squared bin stream in, per-frame flux results out.
// Stream: a beat transfers when mag_valid is 1; there is no ready, so every valid beat is consumed.
// frame_done marks a frame end; flux_valid and beat_valid are single-cycle pulses.
interface spectral_flux_banded_if #(
    parameter int N            = 1024,
    parameter int W            = 32,
    parameter int NUM_BANDS    = 4,
    parameter int THRESH_SHIFT = 1
);
    localparam int BIN_W  = $clog2(N);
    localparam int FLUX_W = W + BIN_W;

    logic                           mag_valid;
    logic [W-1:0]                   mag_sq;
    logic [BIN_W-1:0]               bin_index;
    logic                           frame_done;
    logic [FLUX_W-1:0]              flux_value;
    logic [NUM_BANDS*FLUX_W-1:0]    flux_band;
    logic [FLUX_W+THRESH_SHIFT-1:0] threshold;
    logic                           flux_valid;
    logic                           beat_valid;

    modport master (
        output mag_valid, mag_sq, bin_index, frame_done,
        input  flux_value, flux_band, threshold, flux_valid, beat_valid
    );

    modport slave (
        input  mag_valid, mag_sq, bin_index, frame_done,
        output flux_value, flux_band, threshold, flux_valid, beat_valid
    );
endinterface

// File: rtl/spectral_flux_banded.sv
// Banded spectral flux with moving-average adaptive threshold and beat flagging, 4-cycle latency.
// Optional beat hold-off after each beat: define SFLUX_REFRACTORY_EN.
module spectral_flux_banded #(
    parameter int N              = 1024,
    parameter int W              = 32,
    parameter int NUM_BANDS      = 4,
    parameter int HIST_DEPTH     = 32,
    parameter int THRESH_SHIFT   = 1,
    parameter int REFRACT_FRAMES = 4
) (
    input  logic clk,
    input  logic reset,
    spectral_flux_banded_if.slave bus
);
    localparam int BIN_W      = $clog2(N);
    localparam int FLUX_W     = W + BIN_W;
    localparam int LOG2_NB    = $clog2(NUM_BANDS);
    localparam int BAND_W     = (NUM_BANDS > 1) ? LOG2_NB : 1;
    localparam int BAND_SHIFT = BIN_W - LOG2_NB;
    localparam int LOG2_HD    = $clog2(HIST_DEPTH);
    localparam int HSUM_W     = FLUX_W + LOG2_HD;
    localparam int THR_W      = FLUX_W + THRESH_SHIFT;
    localparam int WARM_W     = $clog2(HIST_DEPTH + 1);

    // S1: register the beat and read the previous frame's magnitude
    logic [W-1:0]     prev_mag [N];
    logic             first_frame;
    logic             s1_valid, s1_marker, s1_first;
    logic [W-1:0]     s1_mag, s1_prev;
    logic [BIN_W-1:0] s1_bin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_frame <= 1'b1;
            s1_valid    <= 1'b0;
            s1_marker   <= 1'b0;
            s1_first    <= 1'b1;
            s1_mag      <= '0;
            s1_prev     <= '0;
            s1_bin      <= '0;
        end else begin
            s1_valid  <= bus.mag_valid;
            s1_marker <= bus.frame_done;
            s1_first  <= first_frame;
            s1_mag    <= bus.mag_sq;
            s1_bin    <= bus.bin_index;
            // S2 writes the same bin this edge when a bin repeats on consecutive beats
            s1_prev   <= (s1_valid && (s1_bin == bus.bin_index)) ? s1_mag : prev_mag[bus.bin_index];
            if (bus.frame_done)
                first_frame <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid)
            prev_mag[s1_bin] <= s1_mag;
    end

    // S2: unsigned half-wave rectified difference
    logic [W-1:0]      pos_diff;
    logic [BAND_W-1:0] band_sel;
    logic              s2_marker;
    logic [W-1:0]      s2_diff;
    logic [BAND_W-1:0] s2_band;

    always_comb begin
        pos_diff = '0;
        if (s1_valid && !s1_first && (s1_mag > s1_prev))
            pos_diff = s1_mag - s1_prev;
    end

    assign band_sel = BAND_W'(s1_bin >> BAND_SHIFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_marker <= 1'b0;
            s2_diff   <= '0;
            s2_band   <= '0;
        end else begin
            s2_marker <= s1_marker;
            s2_diff   <= pos_diff;
            s2_band   <= band_sel;
        end
    end

    // S3: per-frame accumulation; a marker latches the totals and restarts the accumulators
    logic [FLUX_W-1:0] diff_ext;
    logic [FLUX_W-1:0] acc_total, frame_total;
    logic [FLUX_W-1:0] acc_band [NUM_BANDS];
    logic [FLUX_W-1:0] frame_band [NUM_BANDS];
    logic              s3_marker;

    assign diff_ext = FLUX_W'(s2_diff);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_marker   <= 1'b0;
            acc_total   <= '0;
            frame_total <= '0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                acc_band[b]   <= '0;
                frame_band[b] <= '0;
            end
        end else begin
            s3_marker <= s2_marker;
            if (s2_marker) begin
                frame_total <= acc_total + diff_ext;
                acc_total   <= '0;
            end else begin
                acc_total <= acc_total + diff_ext;
            end
            for (int b = 0; b < NUM_BANDS; b++) begin
                if (s2_marker) begin
                    frame_band[b] <= acc_band[b] + ((s2_band == BAND_W'(b)) ? diff_ext : '0);
                    acc_band[b]   <= '0;
                end else if (s2_band == BAND_W'(b)) begin
                    acc_band[b] <= acc_band[b] + diff_ext;
                end
            end
        end
    end

    // S4: decision against the history of previous frames, then history update
    logic [FLUX_W-1:0] hist [HIST_DEPTH];
    logic [HSUM_W-1:0] hist_sum;
    logic [LOG2_HD-1:0] hist_ptr;
    logic [WARM_W-1:0] warm_cnt;
    logic              warm;
    logic [THR_W-1:0]  thr_now;
    logic              refract_clear;
    logic              beat_now;

    logic [FLUX_W-1:0] out_flux;
    logic [FLUX_W-1:0] out_band [NUM_BANDS];
    logic [THR_W-1:0]  out_thr;
    logic              out_flux_valid, out_beat_valid;
    logic [NUM_BANDS*FLUX_W-1:0] band_flat;

    assign warm     = (warm_cnt == WARM_W'(HIST_DEPTH));
    assign thr_now  = THR_W'(hist_sum >> LOG2_HD) << THRESH_SHIFT;
    assign beat_now = warm && refract_clear && (THR_W'(frame_total) > thr_now);

`ifdef SFLUX_REFRACTORY_EN
    localparam int REF_W = (REFRACT_FRAMES > 0) ? $clog2(REFRACT_FRAMES + 1) : 1;
    logic [REF_W-1:0] refract_cnt;

    assign refract_clear = (refract_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refract_cnt <= '0;
        end else if (s3_marker) begin
            if (beat_now)
                refract_cnt <= REF_W'(REFRACT_FRAMES);
            else if (refract_cnt != '0)
                refract_cnt <= refract_cnt - REF_W'(1);
        end
    end
`else
    logic unused_refract;
    assign unused_refract = (REFRACT_FRAMES > 0);
    assign refract_clear  = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_flux_valid <= 1'b0;
            out_beat_valid <= 1'b0;
            out_flux       <= '0;
            out_thr        <= '0;
            hist_sum       <= '0;
            hist_ptr       <= '0;
            warm_cnt       <= '0;
            for (int b = 0; b < NUM_BANDS; b++)
                out_band[b] <= '0;
            for (int i = 0; i < HIST_DEPTH; i++)
                hist[i] <= '0;
        end else begin
            out_flux_valid <= s3_marker;
            out_beat_valid <= s3_marker && beat_now;
            if (s3_marker) begin
                out_flux       <= frame_total;
                out_thr        <= thr_now;
                for (int b = 0; b < NUM_BANDS; b++)
                    out_band[b] <= frame_band[b];
                hist_sum       <= hist_sum + HSUM_W'(frame_total) - HSUM_W'(hist[hist_ptr]);
                hist[hist_ptr] <= frame_total;
                hist_ptr       <= hist_ptr + LOG2_HD'(1);
                if (!warm)
                    warm_cnt <= warm_cnt + WARM_W'(1);
            end
        end
    end

    always_comb begin
        band_flat = '0;
        for (int b = 0; b < NUM_BANDS; b++)
            band_flat[b*FLUX_W +: FLUX_W] = out_band[b];
    end

    assign bus.flux_value = out_flux;
    assign bus.flux_band  = band_flat;
    assign bus.threshold  = out_thr;
    assign bus.flux_valid = out_flux_valid;
    assign bus.beat_valid = out_beat_valid;
endmodule

// File: tb/tb_spectral_flux_banded.sv
// Self-checking bench for spectral_flux_banded: behavioural model feeds an expected queue, monitor compares pulses.
module tb_spectral_flux_banded;
    localparam int N  = 16;
    localparam int W  = 32;
    localparam int NB = 4;
    localparam int HD = 4;
    localparam int TS = 1;
    localparam int RF = 2;
    localparam int BW = $clog2(N);
    localparam int FW = W + BW;
    localparam int TW = FW + TS;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spectral_flux_banded_if #(.N(N), .W(W), .NUM_BANDS(NB), .THRESH_SHIFT(TS)) bus ();

    spectral_flux_banded #(
        .N(N), .W(W), .NUM_BANDS(NB), .HIST_DEPTH(HD),
        .THRESH_SHIFT(TS), .REFRACT_FRAMES(RF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [FW-1:0]    flux;
        logic [NB*FW-1:0] band;
        logic [TW-1:0]    thr;
        logic             beat;
        logic [31:0]      cyc;
    } exp_t;

    exp_t exp_q[$];
    bit   beat_log[$];
    exp_t mon_e;

    // behavioural reference
    logic [W-1:0]    m_prev [N];
    logic [FW-1:0]   m_hist [HD];
    logic [FW-1:0]   m_band [NB];
    logic [FW-1:0]   m_total;
    logic [FW+1:0]   m_hsum;
    bit              m_first;
    int              m_ptr, m_warm, m_refr;

    task automatic model_reset();
        m_first = 1'b1;
        m_total = '0;
        m_hsum  = '0;
        m_ptr   = 0;
        m_warm  = 0;
        m_refr  = 0;
        for (int b = 0; b < NB; b++) m_band[b] = '0;
        for (int i = 0; i < HD; i++) m_hist[i] = '0;
    endtask

    task automatic model_bin(input logic [W-1:0] m, input int b);
        logic [FW-1:0] d;
        d = '0;
        if (!m_first && m > m_prev[b]) d = FW'(m - m_prev[b]);
        m_total = m_total + d;
        m_band[b / (N / NB)] = m_band[b / (N / NB)] + d;
        m_prev[b] = m;
    endtask

    task automatic model_frame_end();
        exp_t e;
        logic [TW-1:0] thr;
        bit beat;
        thr  = TW'(m_hsum / HD) * (1 << TS);
        beat = (m_warm == HD) && (TW'(m_total) > thr);
`ifdef SFLUX_REFRACTORY_EN
        if (m_refr > 0) begin
            beat = 1'b0;
            m_refr--;
        end else if (beat) begin
            m_refr = RF;
        end
`endif
        e.flux = m_total;
        for (int b = 0; b < NB; b++) e.band[b*FW +: FW] = m_band[b];
        e.thr  = thr;
        e.beat = beat;
        e.cyc  = cyc + 4;
        exp_q.push_back(e);
        m_hsum = m_hsum + (FW+2)'(m_total) - (FW+2)'(m_hist[m_ptr]);
        m_hist[m_ptr] = m_total;
        m_ptr = (m_ptr + 1) % HD;
        if (m_warm < HD) m_warm++;
        m_total = '0;
        for (int b = 0; b < NB; b++) m_band[b] = '0;
        m_first = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.beat_valid && !bus.flux_valid) begin
                total++; bad++;
                $display("FAIL beat_without_flux got=1 want=0 cyc=%0d", cyc);
            end
            if (bus.flux_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_flux_valid got=1 want=0 cyc=%0d", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    beat_log.push_back(bus.beat_valid);
                    total++;
                    if (bus.flux_value !== mon_e.flux) begin
                        bad++;
                        $display("FAIL flux_value got=%0d want=%0d", bus.flux_value, mon_e.flux);
                    end
                    total++;
                    if (bus.flux_band !== mon_e.band) begin
                        bad++;
                        $display("FAIL flux_band got=%h want=%h", bus.flux_band, mon_e.band);
                    end
                    total++;
                    if (bus.threshold !== mon_e.thr) begin
                        bad++;
                        $display("FAIL threshold got=%0d want=%0d", bus.threshold, mon_e.thr);
                    end
                    total++;
                    if (bus.beat_valid !== mon_e.beat) begin
                        bad++;
                        $display("FAIL beat_valid got=%0b want=%0b", bus.beat_valid, mon_e.beat);
                    end
                    total++;
                    if (cyc !== int'(mon_e.cyc)) begin
                        bad++;
                        $display("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, mon_e.cyc);
                    end
                end
            end
        end
    end

    // driver tasks (called at posedge + 1)
    task automatic drive(input logic v, input logic [W-1:0] m, input int b, input logic fd);
        bus.mag_valid  = v;
        bus.mag_sq     = m;
        bus.bin_index  = BW'(b);
        bus.frame_done = fd;
        if (v) model_bin(m, b);
        if (fd) model_frame_end();
        @(posedge clk);
        #1;
        bus.mag_valid  = 1'b0;
        bus.frame_done = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] val);
        for (int b = 0; b < N; b++) drive(1'b1, val, b, b == N - 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout got_pending=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        total++;
        if (bus.flux_value !== '0 || bus.flux_band !== '0 || bus.threshold !== '0 ||
            bus.flux_valid !== 1'b0 || bus.beat_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s got=%0d/%h/%0d/%0b/%0b want=all_zero", tag, bus.flux_value,
                     bus.flux_band, bus.threshold, bus.flux_valid, bus.beat_valid);
        end
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b1;
        #1;
        check_outputs_zero("reset_outputs");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_outputs_zero("after_reset_outputs");
    endtask

    task automatic test_first_frame();
        beat_log.delete();
        send_frame(100);
        wait_drain();
        check_val("first_frame_flux", 64'(bus.flux_value), 64'd0);
        check_val("first_frame_pulses", 64'(beat_log.size()), 64'd1);
        check_val("flux_valid_is_pulse", 64'(bus.flux_valid), 64'd0);
    endtask

    task automatic test_steady();
        beat_log.delete();
        for (int k = 1; k <= 6; k++) send_frame(W'(10 * k));
        wait_drain();
        check_val("steady_flux", 64'(bus.flux_value), 64'd160);
        for (int b = 0; b < NB; b++)
            check_val("steady_band", 64'(bus.flux_band[b*FW +: FW]), 64'd40);
        check_val("steady_threshold", 64'(bus.threshold), 64'd320);
        check_val("steady_beats", 64'(beat_log.sum() with (int'(item))), 64'd0);
    endtask

    task automatic test_beat();
        beat_log.delete();
        send_frame(100);
        wait_drain();
        check_val("beat_flux", 64'(bus.flux_value), 64'd640);
        check_val("beat_threshold", 64'(bus.threshold), 64'd320);
        check_val("beat_flag", 64'((beat_log.size() == 1) && beat_log[0]), 64'd1);
    endtask

    task automatic test_decrease();
        beat_log.delete();
        send_frame(0);
        wait_drain();
        check_val("decrease_flux", 64'(bus.flux_value), 64'd0);
        check_val("decrease_bands", 64'(bus.flux_band == '0), 64'd1);
        check_val("decrease_threshold", 64'(bus.threshold), 64'd560);
        check_val("decrease_beat", 64'((beat_log.size() == 1) && !beat_log[0]), 64'd1);
    endtask

    task automatic test_back_to_back();
        int perm[N];
        int nb, j, tmp;
        bit fd_last;
        for (int f = 0; f < 24; f++) begin
            if (f % 6 == 4) begin
                for (int r = 0; r < 3; r++) drive(1'b1, W'($urandom_range(0, 5000)), 0, 1'b1);
            end else begin
                nb = (f % 6 == 5) ? 0 : $urandom_range(1, N);
                for (int i = 0; i < N; i++) perm[i] = i;
                for (int i = N - 1; i > 0; i--) begin
                    j = $urandom_range(0, i);
                    tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
                end
                fd_last = (nb > 0) && ($urandom_range(0, 1) == 1);
                for (int i = 0; i < nb; i++) begin
                    if ($urandom_range(0, 3) == 0) drive(1'b0, '0, 0, 1'b0);
                    if ($urandom_range(0, 7) == 0) drive(1'b1, W'($urandom_range(0, 5000)), perm[i], 1'b0);
                    drive(1'b1, W'($urandom_range(0, 5000)), perm[i], fd_last && (i == nb - 1));
                end
                if (!fd_last) drive(1'b0, '0, 0, 1'b1);
            end
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_frame();
        for (int b = 0; b < 5; b++) drive(1'b1, W'(700 + b), b, 1'b0);
        bus.mag_valid = 1'b1;
        bus.mag_sq    = W'(900);
        bus.bin_index = BW'(5);
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("mid_frame_reset_outputs");
        bus.mag_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        beat_log.delete();
        send_frame(50);
        wait_drain();
        check_val("post_reset_first_flux", 64'(bus.flux_value), 64'd0);
        send_frame(60);
        wait_drain();
        check_val("post_reset_second_flux", 64'(bus.flux_value), 64'd160);
        check_val("post_reset_pulses", 64'(beat_log.size()), 64'd2);
    endtask

`ifdef SFLUX_REFRACTORY_EN
    task automatic test_refractory();
        logic [W-1:0] vals[9];
        bit exp_pat[4];
        vals = '{0, 0, 0, 0, 0, 1, 3, 6, 10};
        exp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        beat_log.delete();
        for (int f = 0; f < 9; f++) send_frame(vals[f]);
        wait_drain();
        check_val("refract_pulses", 64'(beat_log.size()), 64'd9);
        if (beat_log.size() == 9)
            for (int i = 0; i < 4; i++)
                check_val("refract_pattern", 64'(beat_log[5 + i]), 64'(exp_pat[i]));
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mag_valid  = 1'b0;
        bus.mag_sq     = '0;
        bus.bin_index  = '0;
        bus.frame_done = 1'b0;
        reset          = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_first_frame();
        test_steady();
        test_beat();
        test_decrease();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef SFLUX_REFRACTORY_EN
        test_refractory();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
